// File: rtl/debug_controller_if.sv
// Host-side command/response channels of the debug controller.
// The host (master) issues commands; the controller (slave) returns one response per command.
interface debug_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/debug_controller.sv
// Debug front end: sequences host commands against the core's debug port.
// Define DBG_SINGLE_STEP_EN to enable the STEP command (op 7); otherwise op 7 is rejected.
module debug_controller #(
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned RST_CYCLES   = 4,
  parameter bit          HALT_ON_RST  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  debug_controller_if.slave   host,
  output logic                halt,
  output logic                exec,
  output logic [31:0]         ins,
  output logic                reg_write,
  output logic [4:0]          rd_addr,
  output logic [31:0]         rd_value,
  output logic [4:0]          rs_addr,
  input  logic [31:0]         rs_value,
  output logic                core_nrst
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned RstW   = $clog2(RST_CYCLES + 1);
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);
  localparam logic [RstW-1:0]   RstLoad   = RstW'(RST_CYCLES - 1);

  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpHalt   = 3'd1;
  localparam logic [2:0] OpResume = 3'd2;
  localparam logic [2:0] OpExec   = 3'd3;
  localparam logic [2:0] OpRegRd  = 3'd4;
  localparam logic [2:0] OpRegWr  = 3'd5;
  localparam logic [2:0] OpReset  = 3'd6;

`ifdef DBG_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    StIdle, StDrain, StExec, StRegRd, StWr, StRstP, StStep, StResp
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StDrain, StExec, StRegRd, StWr, StRstP, StResp
  } state_e;
`endif

  state_e             state_q, state_d;
  logic               halt_q, halt_d;
  logic               exec_q, exec_d;
  logic [31:0]        ins_q, ins_d;
  logic               reg_write_q, reg_write_d;
  logic [4:0]         rd_addr_q, rd_addr_d;
  logic [31:0]        rd_value_q, rd_value_d;
  logic [4:0]         rs_addr_q, rs_addr_d;
  logic               core_nrst_q, core_nrst_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DrainW-1:0]  drain_cnt_q, drain_cnt_d;
  logic [RstW-1:0]    rst_cnt_q, rst_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      halt_q      <= HALT_ON_RST;
      exec_q      <= 1'b0;
      ins_q       <= '0;
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_value_q  <= '0;
      rs_addr_q   <= '0;
      core_nrst_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      drain_cnt_q <= '0;
      rst_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      exec_q      <= exec_d;
      ins_q       <= ins_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_value_q  <= rd_value_d;
      rs_addr_q   <= rs_addr_d;
      core_nrst_q <= core_nrst_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      drain_cnt_q <= drain_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    exec_d      = 1'b0;
    ins_d       = '0;
    reg_write_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_value_d  = rd_value_q;
    rs_addr_d   = rs_addr_q;
    core_nrst_d = core_nrst_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    drain_cnt_d = drain_cnt_q;
    rst_cnt_d   = rst_cnt_q;

    unique case (state_q)
      StIdle: begin
        // Core reset is released on the first idle cycle after controller reset.
        core_nrst_d = 1'b1;
        if (host.cmd_valid) begin
          state_d    = StResp;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (host.cmd_op)
            OpNop: ;
            OpHalt: begin
              halt_d = 1'b1;
              if (!halt_q) begin
                drain_cnt_d = DrainLoad;
                state_d     = StDrain;
              end
            end
            OpResume: halt_d = 1'b0;
            OpExec: begin
              if (!halt_q) begin
                rsp_err_d = 1'b1;
              end else begin
                exec_d  = 1'b1;
                ins_d   = host.cmd_data;
                state_d = StExec;
              end
            end
            OpRegRd: begin
              if (!halt_q) begin
                rsp_err_d = 1'b1;
              end else begin
                rs_addr_d = host.cmd_addr;
                state_d   = StRegRd;
              end
            end
            OpRegWr: begin
              if (!halt_q) begin
                rsp_err_d = 1'b1;
              end else begin
                rd_addr_d   = host.cmd_addr;
                rd_value_d  = host.cmd_data;
                reg_write_d = 1'b1;
                state_d     = StWr;
              end
            end
            OpReset: begin
              core_nrst_d = 1'b0;
              rst_cnt_d   = RstLoad;
              state_d     = StRstP;
            end
            default: begin
`ifdef DBG_SINGLE_STEP_EN
              if (!halt_q) begin
                rsp_err_d = 1'b1;
              end else begin
                halt_d  = 1'b0;
                state_d = StStep;
              end
`else
              rsp_err_d = 1'b1;
`endif
            end
          endcase
        end
      end
      StDrain: begin
        if (drain_cnt_q == '0) state_d = StResp;
        else                   drain_cnt_d = drain_cnt_q - DrainW'(1);
      end
      StExec: begin
        drain_cnt_d = DrainLoad;
        state_d     = StDrain;
      end
      StRegRd: begin
        rsp_data_d = rs_value;
        state_d    = StResp;
      end
      StWr: state_d = StResp;
      StRstP: begin
        if (rst_cnt_q == '0) begin
          core_nrst_d = 1'b1;
          state_d     = StResp;
        end else begin
          rst_cnt_d = rst_cnt_q - RstW'(1);
        end
      end
`ifdef DBG_SINGLE_STEP_EN
      // Halt was dropped for exactly one cycle; re-assert and let the fetched instruction retire.
      StStep: begin
        halt_d      = 1'b1;
        drain_cnt_d = DrainLoad;
        state_d     = StDrain;
      end
`endif
      StResp: begin
        if (host.rsp_ready) begin
          state_d    = StIdle;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign host.cmd_ready = (state_q == StIdle);
  assign host.rsp_valid = (state_q == StResp);
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_err   = rsp_err_q;

  assign halt      = halt_q;
  assign exec      = exec_q;
  assign ins       = ins_q;
  assign reg_write = reg_write_q;
  assign rd_addr   = rd_addr_q;
  assign rd_value  = rd_value_q;
  assign rs_addr   = rs_addr_q;
  assign core_nrst = core_nrst_q;

endmodule

// File: tb/tb_debug_controller.sv
// Self-checking bench for debug_controller: directed vector table, reset/abort sequences and
// randomized commands against a command-level model. Honours DBG_SINGLE_STEP_EN if defined.
module tb_debug_controller;

  localparam int D = 5;
  localparam int R = 4;
`ifdef DBG_SINGLE_STEP_EN
  localparam bit StepEn = 1'b1;
`else
  localparam bit StepEn = 1'b0;
`endif

  localparam logic [2:0] OP_NOP = 3'd0, OP_HALT = 3'd1, OP_RESUME = 3'd2, OP_EXEC = 3'd3;
  localparam logic [2:0] OP_RD = 3'd4, OP_WR = 3'd5, OP_RESET = 3'd6, OP_STEP = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt, exec, reg_write, core_nrst;
  logic [31:0] ins, rd_value, rs_value;
  logic [4:0]  rd_addr, rs_addr;

  debug_controller_if bus_if ();

  debug_controller #(
    .DRAIN_CYCLES (D),
    .RST_CYCLES   (R),
    .HALT_ON_RST  (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (bus_if),
    .halt      (halt),
    .exec      (exec),
    .ins       (ins),
    .reg_write (reg_write),
    .rd_addr   (rd_addr),
    .rd_value  (rd_value),
    .rs_addr   (rs_addr),
    .rs_value  (rs_value),
    .core_nrst (core_nrst)
  );

  always #5 clk = ~clk;

  // Core register-file stand-in
  logic [31:0] core_regs [32] = '{default: '0};
  always @(posedge clk) if (reg_write && rd_addr != 5'd0) core_regs[rd_addr] <= rd_value;
  assign rs_value = (rs_addr == 5'd0) ? 32'd0 : core_regs[rs_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Command-level reference model
  typedef struct {
    int          lat;
    bit          err;
    logic [31:0] rdata;
    int          exec_n;
    int          wr_n;
    int          nrst_low;
    int          halt_low;
    bit          halted;
    logic [4:0]  rs;
  } exp_t;

  bit          m_halted = 1'b0;
  logic [4:0]  m_rs     = '0;
  logic [31:0] m_regs [32] = '{default: '0};

  task automatic model_cmd(input logic [2:0] op, input logic [4:0] addr, input logic [31:0] data,
                           output exp_t e);
    bit pre = m_halted;
    e = '{lat: 1, err: 1'b0, rdata: 32'd0, exec_n: 0, wr_n: 0, nrst_low: 0, halt_low: 0,
          halted: 1'b0, rs: 5'd0};
    case (op)
      OP_HALT: begin e.lat = pre ? 1 : 1 + D; m_halted = 1'b1; end
      OP_RESUME: m_halted = 1'b0;
      OP_EXEC: if (!pre) e.err = 1'b1; else begin e.lat = 2 + D; e.exec_n = 1; end
      OP_RD: begin
        if (!pre) e.err = 1'b1;
        else begin
          e.lat = 2;
          e.rdata = (addr == 0) ? 32'd0 : m_regs[addr];
          m_rs = addr;
        end
      end
      OP_WR: begin
        if (!pre) e.err = 1'b1;
        else begin
          e.lat = 2;
          e.wr_n = 1;
          if (addr != 0) m_regs[addr] = data;
        end
      end
      OP_RESET: begin e.lat = 1 + R; e.nrst_low = R; end
      OP_STEP: if (StepEn && pre) e.lat = 2 + D; else e.err = 1'b1;
      default: ;
    endcase
    if (!pre) e.halt_low = (op == OP_HALT) ? 0 : e.lat;
    else      e.halt_low = (op == OP_RESUME || (op == OP_STEP && !e.err)) ? 1 : 0;
    e.halted = m_halted;
    e.rs = m_rs;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [4:0] addr, input logic [31:0] data,
                         input int delay, output int lat, output logic err,
                         output logic [31:0] rdata);
    exp_t        e;
    int          waited = 0;
    int          exec_n = 0, wr_n = 0, nrst_n = 0, halt_n = 0;
    logic [31:0] ins_seen = '0, wr_val_seen = '0;
    logic [4:0]  wr_addr_seen = '0;
    model_cmd(op, addr, data, e);
    @(negedge clk);
    while (!bus_if.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_idle", 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_data  = data;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus_if.cmd_valid = 1'b0;
      if (exec) begin exec_n++; ins_seen = ins; end
      if (reg_write) begin wr_n++; wr_addr_seen = rd_addr; wr_val_seen = rd_value; end
      if (!halt) halt_n++;
      if (!core_nrst) nrst_n++;
    end while (!bus_if.rsp_valid && lat < 100);
    err   = bus_if.rsp_err;
    rdata = bus_if.rsp_data;
    check("rsp_latency", 32'(lat), 32'(e.lat));
    check("rsp_err", 32'(err), 32'(e.err));
    check("rsp_data", rdata, e.rdata);
    check("exec_pulses", 32'(exec_n), 32'(e.exec_n));
    check("exec_ins", ins_seen, (e.exec_n != 0) ? data : 32'd0);
    check("wr_pulses", 32'(wr_n), 32'(e.wr_n));
    check("wr_addr", 32'(wr_addr_seen), (e.wr_n != 0) ? 32'(addr) : 32'd0);
    check("wr_value", wr_val_seen, (e.wr_n != 0) ? data : 32'd0);
    check("nrst_low_cycles", 32'(nrst_n), 32'(e.nrst_low));
    check("halt_low_cycles", 32'(halt_n), 32'(e.halt_low));
    check("halt_level", 32'(halt), 32'(e.halted));
    check("rs_addr", 32'(rs_addr), 32'(e.rs));
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      check("rsp_hold", 32'(bus_if.rsp_valid && !bus_if.cmd_ready && bus_if.rsp_data == rdata
                            && bus_if.rsp_err == err), 32'd1);
    end
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    check("back_to_idle", 32'(bus_if.cmd_ready && !bus_if.rsp_valid), 32'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  addr;
    logic [31:0] data;
    int          delay;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          quiet;

    vecs[0]  = '{OP_HALT,   5'd0, 32'd0,          0, 1 + D, 1'b0, 32'd0};
    vecs[1]  = '{OP_WR,     5'd5, 32'hDEADBEEF,   0, 2,     1'b0, 32'd0};
    vecs[2]  = '{OP_RD,     5'd5, 32'd0,          2, 2,     1'b0, 32'hDEADBEEF};
    vecs[3]  = '{OP_EXEC,   5'd0, 32'h00100093,   0, 2 + D, 1'b0, 32'd0};
    vecs[4]  = '{OP_WR,     5'd0, 32'h12345678,   0, 2,     1'b0, 32'd0};
    vecs[5]  = '{OP_RD,     5'd0, 32'd0,          1, 2,     1'b0, 32'd0};
    vecs[6]  = '{OP_RESET,  5'd0, 32'd0,          3, 1 + R, 1'b0, 32'd0};
    vecs[7]  = '{OP_HALT,   5'd0, 32'd0,          0, 1,     1'b0, 32'd0};
    vecs[8]  = '{OP_STEP,   5'd0, 32'd0,          0, StepEn ? 2 + D : 1, !StepEn, 32'd0};
    vecs[9]  = '{OP_RESUME, 5'd0, 32'd0,          0, 1,     1'b0, 32'd0};
    vecs[10] = '{OP_RD,     5'd5, 32'd0,          0, 1,     1'b1, 32'd0};
    vecs[11] = '{OP_EXEC,   5'd0, 32'h00100093,   0, 1,     1'b1, 32'd0};
    vecs[12] = '{OP_WR,     5'd6, 32'hCAFEF00D,   0, 1,     1'b1, 32'd0};
    vecs[13] = '{OP_STEP,   5'd0, 32'd0,          0, 1,     1'b1, 32'd0};
    vecs[14] = '{OP_NOP,    5'd0, 32'd0,          1, 1,     1'b0, 32'd0};

    rst = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = '0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_data  = '0;
    bus_if.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_core_nrst", 32'(core_nrst), 32'd0);
    check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("rst_quiet", 32'({bus_if.rsp_valid, exec, reg_write, rs_addr, rd_addr}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("core_nrst_release", 32'(core_nrst), 32'd1);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].delay, lat, err, rdata);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("vec%0d_data", i), rdata, vecs[i].rdata);
    end

    // Reset in the middle of a HALT drain: command aborted, no response issued
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = OP_HALT;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    check("abort_halt_set", 32'(halt), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_halted = 1'b0;
    m_rs = '0;
    quiet = 0;
    for (int k = 0; k < D + 3; k++) begin
      @(negedge clk);
      if (!bus_if.rsp_valid && bus_if.cmd_ready) quiet++;
    end
    check("abort_no_rsp", 32'(quiet), 32'(D + 3));
    check("abort_halt", 32'(halt), 32'd0);

    for (int n = 0; n < 150; n++) begin
      logic [2:0] op = 3'($urandom_range(0, 7));
      run_cmd(op, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3), lat, err, rdata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
